// File: rtl/lcm_pkg.sv
// Shared types and constants for the sequential LCM engine.
// State encoding, default operand width and the result-width helper live here.
package lcm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int LCM_W_DEF = 16;

    // The LCM of two W-bit operands always fits in twice the operand width.
    function automatic int lcm_res_w(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/lcm_datapath.sv
// Combinational compare/add stage of the LCM engine: compares the two running
// multiples and forms the next multiple of each operand.
module lcm_datapath
    import lcm_pkg::*;
#(
    parameter int W = LCM_W_DEF
) (
    input  logic [lcm_res_w(W)-1:0] ma,
    input  logic [lcm_res_w(W)-1:0] mb,
    input  logic [W-1:0]            a,
    input  logic [W-1:0]            b,
    output logic                    eq,
    output logic                    lt,
    output logic [lcm_res_w(W)-1:0] ma_next,
    output logic [lcm_res_w(W)-1:0] mb_next
);

    localparam int RW = lcm_res_w(W);

    // Each multiple only grows while below the other, so neither exceeds the
    // LCM and the 2W-bit sums never wrap.
    always_comb begin
        eq      = (ma == mb);
        lt      = (ma < mb);
        ma_next = ma + {{(RW-W){1'b0}}, a};
        mb_next = mb + {{(RW-W){1'b0}}, b};
    end

endmodule

// File: rtl/lcm_seq.sv
// Sequential least-common-multiple engine (repeated addition of two multiples).
// Optional iteration counter and iters port enabled by defining LCM_ITER_COUNT_EN.
module lcm_seq
    import lcm_pkg::*;
#(
    parameter int W     = LCM_W_DEF,
    parameter int CNT_W = W + 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [W-1:0]            a,
    input  logic [W-1:0]            b,
    output logic                    ready,
    output logic                    done,
    output logic [lcm_res_w(W)-1:0] lcm
`ifdef LCM_ITER_COUNT_EN
    ,
    output logic [CNT_W-1:0]        iters
`endif
);

    localparam int RW = lcm_res_w(W);

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [RW-1:0]   ma;
    logic [RW-1:0]   mb;
    logic [RW-1:0]   ma_next;
    logic [RW-1:0]   mb_next;
    logic            eq;
    logic            lt;
    logic            zero_op;

    lcm_datapath #(.W(W)) u_dp (
        .ma      (ma),
        .mb      (mb),
        .a       (a_r),
        .b       (b_r),
        .eq      (eq),
        .lt      (lt),
        .ma_next (ma_next),
        .mb_next (mb_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A zero operand still passes through RUN for one cycle so its done strobe
    // lines up with the equal-operand case (done after the edge following start).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (zero_op || eq) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
        done  = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            ma      <= '0;
            mb      <= '0;
            lcm     <= '0;
            zero_op <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        ma      <= {{(RW-W){1'b0}}, a};
                        mb      <= {{(RW-W){1'b0}}, b};
                        zero_op <= (a == '0) || (b == '0);
                    end
                end
                RUN: begin
                    if (zero_op)  lcm <= '0;
                    else if (eq)  lcm <= ma;
                    else if (lt)  ma  <= ma_next;
                    else          mb  <= mb_next;
                end
                default: ;
            endcase
        end
    end

`ifdef LCM_ITER_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   iters <= '0;
        else if (state == IDLE && start)           iters <= '0;
        else if (state == RUN && !zero_op && !eq)  iters <= iters + 1'b1;
    end
`endif

endmodule

// File: tb/tb_lcm_seq.sv
// Self-checking bench for lcm_seq: vector table, hand sequences, worst case and
// a random sweep, all checked through an expected-result queue.
module tb_lcm_seq;

    localparam int BUDGET = 200000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        done;
    logic [31:0] lcm;
`ifdef LCM_ITER_COUNT_EN
    logic [17:0] iters;
`endif

    lcm_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .lcm   (lcm)
`ifdef LCM_ITER_COUNT_EN
        ,
        .iters (iters)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        longint      exp_lcm;
        int          exp_iters;
    } vec_t;

    typedef struct {
        longint lcm;
        int     iters;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic longint ref_lcm(input longint x, input longint y);
        longint p, q, t;
        if (x == 0 || y == 0) return 0;
        p = x;
        q = y;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return (x / p) * y;
    endfunction

    function automatic int ref_iters(input longint x, input longint y);
        longint l;
        l = ref_lcm(x, y);
        if (l == 0) return 0;
        return int'(l / x + l / y - 2);
    endfunction

    // Called and returns at a negedge. Launches one operation, scrambles the
    // ports during RUN, and checks result, latency, hold and handshake.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_,
                         input longint exp_lcm, input int exp_iters);
        exp_t        e;
        logic [31:0] prev;
        int          lat;
        bit          held;
        bit          rdy_ok;
        e.lcm   = exp_lcm;
        e.iters = exp_iters;
        sb.push_back(e);
        prev  = lcm;
        a     = ta;
        b     = tb_;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        lat    = 0;
        held   = 1'b1;
        rdy_ok = 1'b1;
        @(negedge clk);
        while (!done && lat < BUDGET) begin
            if (lcm !== prev) held = 1'b0;
            if (ready !== 1'b0) rdy_ok = 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        e = sb.pop_front();
        chk("done_seen", longint'(done), 1);
        if (done) begin
            chk("lcm", longint'(lcm), e.lcm);
            chk("latency", longint'(lat), longint'(e.iters + 1));
            chk("lcm_held_during_run", longint'(held), 1);
            chk("ready_low_while_busy", longint'(rdy_ok), 1);
`ifdef LCM_ITER_COUNT_EN
            chk("iters", longint'(iters), longint'(e.iters));
`endif
            @(negedge clk);
            chk("done_one_cycle", longint'(done), 0);
            chk("ready_after_done", longint'(ready), 1);
        end
    endtask

    initial begin
        int          pulses;
        logic [31:0] got;
        exp_t        e;
        logic [15:0] ra, rb;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("reset_ready", longint'(ready), 1);
        chk("reset_done", longint'(done), 0);
        chk("reset_lcm", longint'(lcm), 0);
`ifdef LCM_ITER_COUNT_EN
        chk("reset_iters", longint'(iters), 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        vecs.push_back('{16'd4,     16'd6,     64'd12,    3});
        vecs.push_back('{16'd6,     16'd4,     64'd12,    3});
        vecs.push_back('{16'd7,     16'd7,     64'd7,     0});
        vecs.push_back('{16'd0,     16'd5,     64'd0,     0});
        vecs.push_back('{16'd9,     16'd0,     64'd0,     0});
        vecs.push_back('{16'd1,     16'd1,     64'd1,     0});
        vecs.push_back('{16'd3,     16'd5,     64'd15,    6});
        vecs.push_back('{16'd100,   16'd75,    64'd300,   5});
        vecs.push_back('{16'd255,   16'd256,   64'd65280, 509});
        vecs.push_back('{16'd1,     16'd1000,  64'd1000,  999});
        vecs.push_back('{16'd65535, 16'd65535, 64'd65535, 0});
        for (int i = 0; i < vecs.size(); i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].exp_lcm, vecs[i].exp_iters);

        // Start pulsed during RUN with different operands must be ignored.
        e.lcm   = 36;
        e.iters = 3;
        sb.push_back(e);
        a = 16'd12;
        b = 16'd18;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("busy_ready", longint'(ready), 0);
        a = 16'd1;
        b = 16'd1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        pulses = 0;
        got    = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                got = lcm;
            end
        end
        e = sb.pop_front();
        chk("ignored_start_pulses", longint'(pulses), 1);
        chk("ignored_start_lcm", longint'(got), e.lcm);
`ifdef LCM_ITER_COUNT_EN
        chk("ignored_start_iters", longint'(iters), longint'(e.iters));
`endif
        chk("ignored_start_ready", longint'(ready), 1);

        // Reset in the middle of RUN aborts without a done strobe.
        a = 16'd9;
        b = 16'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        #2 rst = 1'b1;
        #1;
        chk("midrun_reset_ready", longint'(ready), 1);
        chk("midrun_reset_lcm", longint'(lcm), 0);
`ifdef LCM_ITER_COUNT_EN
        chk("midrun_reset_iters", longint'(iters), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("midrun_reset_no_done", longint'(pulses), 0);
        chk("midrun_reset_lcm_after", longint'(lcm), 0);

        do_op(16'd65535, 16'd65534, 64'h0000_0000_FFFD_0002, 131067);

        for (int i = 0; i < 2000; i++) begin
            ra = 16'($urandom_range(15, 1));
            rb = 16'($urandom_range(15, 1));
            do_op(ra, rb, ref_lcm(longint'(ra), longint'(rb)),
                  ref_iters(longint'(ra), longint'(rb)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
